nibble_serial_add_ctrl: RTL

- Sequencer that performs WIDTH-bit add/subtract by time-multiplexing one external 4-bit ripple adder, one nibble per clock, LSB nibble first.
- Owns operand/result registers, the inter-nibble carry register and the valid/ready handshakes.
- The 4-bit adder stays a separate combinational instance, connected through the adx/ady/adci/ads/adco ports.
- Used wherever wide arithmetic is needed but only one 4-bit adder slice is available.

---
 rtl/nibble_serial_add_ctrl_if.sv | 30 +++
 rtl/nibble_serial_add_ctrl.sv | 99 +++++++++
 2 files changed

// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if: operand request / result response bundle for the nibble-serial adder controller.
// Ports (signals):
//   in_valid/in_ready         operand handshake
//   in_a, in_b, in_ci, in_sub operands, carry/borrow-in, subtract select
//   out_valid/out_ready       result handshake
//   out_sum, out_co, out_ovf  result, final carry (sub: 1 = no borrow), signed overflow
// Modports: master = requester/consumer side, slave = controller side.
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_ci;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_co;
    logic             out_ovf;
    modport master (
        output in_valid, in_a, in_b, in_ci, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_co, out_ovf
    );
    modport slave (
        input  in_valid, in_a, in_b, in_ci, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_co, out_ovf
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: WIDTH-bit add/subtract sequenced through one external 4-bit adder, LSB nibble first.
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   bus (slave)    operand/result handshakes and data
//   adx, ady, adci operand nibbles and carry-in driven to the external adder (0 outside RUN)
//   ads, adco      sum nibble and carry-out returned by the external adder
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    nibble_serial_add_ctrl_if.slave bus,
    output logic [3:0]              adx,
    output logic [3:0]              ady,
    output logic                    adci,
    input  logic [3:0]              ads,
    input  logic                    adco
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = NIB > 1 ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, sum_q, sum_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             carry_q, carry_d, co_q, co_d, ovf_q, ovf_d;
    logic             last;
    assign last          = idx_q == IW'(NIB - 1);
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.out_sum   = sum_q;
    assign bus.out_co    = co_q;
    assign bus.out_ovf   = ovf_q;
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        adx     = 4'h0;
        ady     = 4'h0;
        adci    = 1'b0;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                a_d     = bus.in_a;
                // subtraction is A + ~B + ~borrow_in
                b_d     = bus.in_sub ? ~bus.in_b : bus.in_b;
                carry_d = bus.in_sub ^ bus.in_ci;
                idx_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                adx                = a_q[4*idx_q +: 4];
                ady                = b_q[4*idx_q +: 4];
                adci               = carry_q;
                acc_d[4*idx_q +: 4] = ads;
                carry_d            = adco;
                idx_d              = idx_q + IW'(1);
                if (last) begin
                    // the partial result becomes visible only here, so out_sum holds the old result during RUN
                    sum_d   = acc_d;
                    co_d    = adco;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (ads[3] != a_q[WIDTH-1]);
                    carry_d = 1'b0;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = bus.out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
        end
    end
endmodule
